// File: rtl/uart_pkg.sv
// Shared defaults and the entry layout for the UART receive queue.
package uart_pkg;
   localparam int UART_DATA_W = 8;
   localparam int UART_DEPTH  = 16;

   typedef struct packed {
      logic                   ferr;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and its consumer: first-word fall-through,
// drops on full unless the head leaves that same cycle, sticky overflow flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_ferr,
   input  logic                     in_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_ferr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   input  logic                     ovf_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   typedef struct packed {
      logic              ferr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, drop;

   assign out_valid = (level != '0);
   assign full      = (level == FULL_LVL);
   assign pop       = rst_n && out_valid && out_ready;
   assign push      = rst_n && in_valid && (!full || pop);
   assign drop      = rst_n && in_valid && full && !pop;

   assign out_data  = mem[rd_ptr].data;
   assign out_ferr  = mem[rd_ptr].ferr;

   // No reset on storage so it maps onto distributed RAM with async read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{ferr: in_ferr, data: in_data};
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end
endmodule
